// File: rtl/sel_mac_pipe.sv
// sel_mac_pipe: select one of NCH channels, multiply by a coefficient, load or accumulate, with valid/ready on both sides
// Ports: clk/rst (sync, active-high); in_* beat (data, sel, coef, acc mode, flag) with in_valid/in_ready;
// out_data/out_flag with out_valid/out_ready; err sticky bad-select flag cleared by err_clr; drop_cnt saturating bad-beat count.
module sel_mac_pipe #(
  parameter int W    = 8,
  parameter int NCH  = 3,
  parameter int SELW = 2,
  parameter int AW   = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NCH*W-1:0] in_data,
  input  logic [SELW-1:0]  in_sel,
  input  logic [W-1:0]     in_coef,
  input  logic             in_acc,
  input  logic             in_flag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW-1:0]    out_data,
  output logic             out_flag,
  output logic             err,
  input  logic             err_clr,
  output logic [7:0]       drop_cnt
);
  logic          s1_valid_q, s1_valid_d, s1_bad_q, s1_bad_d, s1_acc_q, s1_acc_d, s1_flag_q, s1_flag_d;
  logic [W-1:0]  s1_ch_q, s1_ch_d, s1_coef_q, s1_coef_d;
  logic          s2_valid_q, s2_valid_d, s2_flag_q, s2_flag_d;
  logic [AW-1:0] acc_q, acc_d, prod;
  logic          err_q, err_d;
  logic [7:0]    drop_q, drop_d;
  logic [W-1:0]  sel_ch;
  logic          bad_in, accept, s1_adv, load2, bad_acc;
  always_comb begin
    sel_ch = '0;
    for (int k = 0; k < NCH; k++) sel_ch = (int'(in_sel) == k) ? in_data[k*W +: W] : sel_ch;
  end
  assign bad_in   = int'(in_sel) >= NCH;
  // bad beats never need S2, so they drain from S1 regardless of backpressure
  assign s1_adv   = s1_valid_q && (s1_bad_q || !s2_valid_q || out_ready);
  assign in_ready = !rst && (!s1_valid_q || s1_adv);
  assign accept   = in_valid && in_ready;
  assign bad_acc  = accept && bad_in;
  assign load2    = s1_adv && !s1_bad_q;
  assign prod     = AW'(s1_ch_q) * AW'(s1_coef_q);
  always_comb begin
    s1_valid_d = accept || (s1_valid_q && !s1_adv);
    s1_ch_d    = accept ? sel_ch : s1_ch_q;
    s1_coef_d  = accept ? in_coef : s1_coef_q;
    s1_acc_d   = accept ? in_acc : s1_acc_q;
    s1_flag_d  = accept ? in_flag : s1_flag_q;
    s1_bad_d   = accept ? bad_in : s1_bad_q;
    s2_valid_d = load2 || (s2_valid_q && !out_ready);
    acc_d      = load2 ? (s1_acc_q ? acc_q + prod : prod) : acc_q;
    s2_flag_d  = load2 ? s1_flag_q : s2_flag_q;
    err_d      = bad_acc || (err_q && !err_clr);
    drop_d     = (bad_acc && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_ch_q    <= '0;
      s1_coef_q  <= '0;
      s1_acc_q   <= 1'b0;
      s1_flag_q  <= 1'b0;
      s1_bad_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      acc_q      <= '0;
      s2_flag_q  <= 1'b0;
      err_q      <= 1'b0;
      drop_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_ch_q    <= s1_ch_d;
      s1_coef_q  <= s1_coef_d;
      s1_acc_q   <= s1_acc_d;
      s1_flag_q  <= s1_flag_d;
      s1_bad_q   <= s1_bad_d;
      s2_valid_q <= s2_valid_d;
      acc_q      <= acc_d;
      s2_flag_q  <= s2_flag_d;
      err_q      <= err_d;
      drop_q     <= drop_d;
    end
  end
  assign out_valid = s2_valid_q;
  assign out_data  = acc_q;
  assign out_flag  = s2_flag_q;
  assign err       = err_q;
  assign drop_cnt  = drop_q;
endmodule

// File: tb/tb_sel_mac_pipe.sv
// tb_sel_mac_pipe: scoreboard bench for sel_mac_pipe with directed vectors
module tb_sel_mac_pipe;
  localparam int W = 8, NCH = 3, SELW = 2, AW = 20;
  logic             clk = 1'b0, rst = 1'b1;
  logic             in_valid = 1'b0, in_ready;
  logic [NCH*W-1:0] in_data = '0;
  logic [SELW-1:0]  in_sel = '0;
  logic [W-1:0]     in_coef = '0;
  logic             in_acc = 1'b0, in_flag = 1'b0;
  logic             out_valid, out_ready = 1'b1;
  logic [AW-1:0]    out_data;
  logic             out_flag, err, err_clr = 1'b0;
  logic [7:0]       drop_cnt;
  int               tests = 0, fails = 0, n_acc = 0;
  logic [AW:0]      sbq[$];
  logic [AW:0]      exp_e, hold_v;
  logic             hold = 1'b0;
  sel_mac_pipe #(.W(W), .NCH(NCH), .SELW(SELW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .in_coef(in_coef), .in_acc(in_acc), .in_flag(in_flag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_flag(out_flag),
    .err(err), .err_clr(err_clr), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic look();
    #3;
  endtask
  task automatic send(input logic [23:0] d, input logic [1:0] s, input logic [7:0] c,
                      input logic a, input logic f, input logic ev, input logic [19:0] e);
    bit got = 0;
    in_valid = 1'b1; in_data = d; in_sel = s; in_coef = c; in_acc = a; in_flag = f;
    for (int n = 0; n < 50 && !got; n++) begin
      #3;
      if (in_ready) begin
        got = 1;
        n_acc++;
        if (ev) sbq.push_back({f, e});
      end
      step();
    end
    in_valid = 1'b0;
    chk("accept", 32'(got), 32'd1);
  endtask
  initial begin
    fork
      forever begin
        @(negedge clk);
        #4;
        if (!rst) begin
          if (hold) chk("hold_stable", 32'({out_flag, out_data}), 32'(hold_v));
          if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL unexpected_out: got %0h expected none", out_data);
            end else begin
              exp_e = sbq.pop_front();
              chk("out_data", 32'(out_data), 32'(exp_e[AW-1:0]));
              chk("out_flag", 32'(out_flag), 32'(exp_e[AW]));
            end
          end
          hold = out_valid && !out_ready;
          hold_v = {out_flag, out_data};
        end else hold = 1'b0;
      end
    join_none
    step();
    repeat (3) begin
      in_valid = 1'($urandom); in_data = 24'($urandom); in_sel = 2'($urandom);
      in_coef = 8'($urandom); in_acc = 1'($urandom); out_ready = 1'($urandom); err_clr = 1'($urandom);
      look();
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_out_flag", 32'(out_flag), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_drop", 32'(drop_cnt), 0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0; rst = 1'b0;
    look();
    chk("post_rst_in_ready", 32'(in_ready), 1);
    step();
    send(24'h001200, 2'd1, 8'h03, 1'b0, 1'b1, 1'b1, 20'h00036);
    look();
    chk("lat_not_early", 32'(out_valid), 0);
    step();
    look();
    chk("lat_valid", 32'(out_valid), 1);
    chk("lat_data", 32'(out_data), 32'h36);
    chk("lat_flag", 32'(out_flag), 1);
    step();
    for (int k = 1; k <= 17; k++)
      send(24'h0000FF, 2'd0, 8'hFF, k > 1, k[0], 1'b1, 20'(k * 32'hFE01));
    repeat (3) step();
    look();
    chk("acc17", 32'(out_data), 32'h0DE11);
    chk("acc17_idle", 32'(out_valid), 0);
    step();
    send(24'h000000, 2'd3, 8'h05, 1'b0, 1'b0, 1'b0, 20'h0);
    look();
    chk("bad_err", 32'(err), 1);
    chk("bad_drop1", 32'(drop_cnt), 1);
    step();
    step();
    look();
    chk("bad_no_valid", 32'(out_valid), 0);
    chk("bad_acc_kept", 32'(out_data), 32'h0DE11);
    step();
    err_clr = 1'b1;
    send(24'h000000, 2'd3, 8'h07, 1'b1, 1'b1, 1'b0, 20'h0);
    err_clr = 1'b0;
    look();
    chk("set_wins", 32'(err), 1);
    chk("bad_drop2", 32'(drop_cnt), 2);
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    look();
    chk("err_cleared", 32'(err), 0);
    chk("drop_kept", 32'(drop_cnt), 2);
    step();
    out_ready = 1'b0;
    n_acc = 0;
    fork
      for (int k = 1; k <= 8; k++)
        send(24'h110000, 2'd2, 8'(k), 1'b0, k[0], 1'b1, 20'(32'h11 * k));
      begin
        repeat (4) step();
        look();
        chk("bp_accepted", 32'(n_acc), 2);
        chk("bp_in_ready", 32'(in_ready), 0);
        step();
        out_ready = 1'b1;
      end
    join
    for (int n = 0; n < 100 && sbq.size() != 0; n++) step();
    chk("bp_drained", 32'(sbq.size()), 0);
    out_ready = 1'b0;
    send(24'h001200, 2'd1, 8'h02, 1'b0, 1'b0, 1'b1, 20'h00024);
    send(24'h001200, 2'd1, 8'h03, 1'b1, 1'b1, 1'b1, 20'h0005A);
    rst = 1'b1;
    sbq.delete();
    look();
    chk("mid_rst_in_ready", 32'(in_ready), 0);
    step();
    look();
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_acc", 32'(out_data), 0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    send(24'h001200, 2'd1, 8'h03, 1'b1, 1'b1, 1'b1, 20'h00036);
    for (int n = 0; n < 20 && sbq.size() != 0; n++) step();
    repeat (2) step();
    chk("final_drained", 32'(sbq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
